// File: rtl/ex1_1_pkg.sv
// rtl/ex1_1_pkg.sv - shared constants and FSM state type for the 3-tap multiply-add block
//
// Purpose : default data width and the run-length FSM state encoding used by
//           ex1_1_window and ex1_1_mac3.
// Ports   : none (package).
package ex1_1_pkg;

   // Default width of data_in / data_out.
   localparam int unsigned DW_DEFAULT = 32;

   // Number of consecutive valid samples seen, saturating at RUN (>= 3).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONE  = 2'd1,
      TWO  = 2'd2,
      RUN  = 2'd3
   } mac_state_e;

endpackage

// File: rtl/ex1_1_window.sv
// rtl/ex1_1_window.sv - 3-entry sample window (two stored taps plus the live sample)
//
// Purpose : keeps the two previous valid samples so the top can form a*b+c,
//           where c is the current sample, b the one before, a the one before that.
// Ports   : clk      in   clock, all state on posedge
//           rst      in   synchronous active-high reset, clears stored taps
//           flush_i  in   invalidates the stored taps (a gap in the valid run)
//           shift_i  in   slide the window by one, loading sample_i
//           sample_i in   DW  current sample
//           a_o      out  DW  sample two valid cycles back
//           b_o      out  DW  sample one valid cycle back
//           c_o      out  DW  current sample (pass-through tap)
module ex1_1_window
   import ex1_1_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          shift_i,
   input  logic [DW-1:0] sample_i,
   output logic [DW-1:0] a_o,
   output logic [DW-1:0] b_o,
   output logic [DW-1:0] c_o
);

   logic [DW-1:0] tap1_q, tap1_d;
   logic [DW-1:0] tap2_q, tap2_d;

   always_comb begin
      tap1_d = tap1_q;
      tap2_d = tap2_q;
      // Flush wins over shift so a stale sample can never survive a gap.
      if (flush_i) begin
         tap1_d = '0;
         tap2_d = '0;
      end else if (shift_i) begin
         tap2_d = tap1_q;
         tap1_d = sample_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tap1_q <= '0;
         tap2_q <= '0;
      end else begin
         tap1_q <= tap1_d;
         tap2_q <= tap2_d;
      end
   end

   assign a_o = tap2_q;
   assign b_o = tap1_q;
   assign c_o = sample_i;

endmodule

// File: rtl/ex1_1_mac3.sv
// rtl/ex1_1_mac3.sv - sliding 3-sample multiply-add: data_out = a*b + c
//
// Purpose : counts consecutive valid samples and, from the third one on,
//           registers a*b+c (unsigned, truncated to DW) one cycle later.
// Config  : EX1_1_MAC3_OVF_EN adds the ovf output (untruncated result > 2^DW-1).
// Ports   : clk      in   clock, all state on posedge
//           rst      in   synchronous active-high reset; also forces outputs to 0
//           validi   in   data_in valid this cycle
//           data_in  in   DW  input sample
//           valido   out  data_out holds a fresh result
//           data_out out  DW  a*b+c, held while valido=0
//           ovf      out  (EX1_1_MAC3_OVF_EN only) result overflowed DW bits
module ex1_1_mac3
   import ex1_1_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          validi,
   input  logic [DW-1:0] data_in,
   output logic          valido,
   output logic [DW-1:0] data_out
`ifdef EX1_1_MAC3_OVF_EN
   ,
   output logic          ovf
`endif
);

   mac_state_e    state_q, state_d;
   logic          fire;
   logic [DW-1:0] win_a, win_b, win_c;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   ex1_1_window #(
      .DW(DW)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (~validi),
      .shift_i  (validi),
      .sample_i (data_in),
      .a_o      (win_a),
      .b_o      (win_b),
      .c_o      (win_c)
   );

   // Run-length FSM: any idle cycle restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      if (validi) begin
         case (state_q)
            IDLE:    state_d = ONE;
            ONE:     state_d = TWO;
            TWO:     state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Two earlier samples are already in the window when we are in TWO or RUN.
   assign fire = validi && ((state_q == TWO) || (state_q == RUN));

`ifdef EX1_1_MAC3_OVF_EN
   logic [2*DW:0] mac_wide;
   logic          ovf_q, ovf_d;

   always_comb begin
      mac_wide = (2*DW+1)'(win_a) * (2*DW+1)'(win_b) + (2*DW+1)'(win_c);
      valid_d  = fire;
      data_d   = data_q;
      ovf_d    = 1'b0;
      if (fire) begin
         data_d = mac_wide[DW-1:0];
         ovf_d  = |mac_wide[2*DW:DW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q & ~rst;
`else
   always_comb begin
      valid_d = fire;
      data_d  = data_q;
      // Width is DW from context, so the product wraps to the low DW bits.
      if (fire) begin
         data_d = win_a * win_b + win_c;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Reset also masks the outputs in the same cycle it is asserted.
   assign valido   = valid_q & ~rst;
   assign data_out = rst ? '0 : data_q;

endmodule

// File: tb/tb_ex1_1_mac3.sv
// tb/tb_ex1_1_mac3.sv - directed vector table plus randomized model check for ex1_1_mac3
module tb_ex1_1_mac3;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          validi;
   logic [DW-1:0] data_in;
   logic          valido;
   logic [DW-1:0] data_out;
`ifdef EX1_1_MAC3_OVF_EN
   logic          ovf;
`endif

   always #5 clk = ~clk;

   ex1_1_mac3 #(
      .DW(DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .validi   (validi),
      .data_in  (data_in),
      .valido   (valido),
      .data_out (data_out)
`ifdef EX1_1_MAC3_OVF_EN
      ,
      .ovf      (ovf)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   typedef struct {
      logic          rst;
      logic          vld;
      logic [DW-1:0] din;
      logic          exp_v;
      logic [DW-1:0] exp_d;
      logic          exp_o;
   } vec_t;

   vec_t tv[$];

   // Reference model state: the valid samples of the current unbroken run.
   logic [DW-1:0] hist[$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ovf;

   task automatic model_edge(input logic r, input logic v, input logic [DW-1:0] d);
      logic [2*DW:0] wide;
      m_ovf = 1'b0;
      if (r) begin
         hist.delete();
         m_valid = 1'b0;
         m_data  = '0;
      end else if (!v) begin
         hist.delete();
         m_valid = 1'b0;
      end else begin
         hist.push_back(d);
         if (hist.size() > 3) void'(hist.pop_front());
         if (hist.size() == 3) begin
            wide    = (2*DW+1)'(hist[0]) * (2*DW+1)'(hist[1]) + (2*DW+1)'(hist[2]);
            m_valid = 1'b1;
            m_data  = wide[DW-1:0];
            m_ovf   = (wide >> DW) != 0;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      validi  = 1'b0;
      data_in = '0;
      hist.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;

      // {rst, validi, data_in, valido, data_out, ovf} observed after the edge
      // Reset with saturated input held valid
      tv.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0});
      tv.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd0,         1'b0, 32'd0, 1'b0});
      // 2,3,4 -> 10
      tv.push_back('{1'b0, 1'b1, 32'd2, 1'b0, 32'd0,  1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd3, 1'b0, 32'd0,  1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd4, 1'b1, 32'd10, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 32'd10, 1'b0});
      // 2,3,4,5 -> 10, 17, then held
      tv.push_back('{1'b0, 1'b1, 32'd2, 1'b0, 32'd10, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd3, 1'b0, 32'd10, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd4, 1'b1, 32'd10, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd5, 1'b1, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd9, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 32'd17, 1'b0});
      // Pattern 1,0,1,1,0,1,1,0 never completes a window
      tv.push_back('{1'b0, 1'b1, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd7, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b0, 32'd7, 1'b0, 32'd17, 1'b0});
      // 0x10000 * 0x10000 + 1 wraps to 1
      tv.push_back('{1'b0, 1'b1, 32'h1_0000, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'h1_0000, 1'b0, 32'd17, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd1,      1'b1, 32'd1,  1'b1});
      tv.push_back('{1'b0, 1'b0, 32'd0,      1'b0, 32'd1,  1'b0});
      // 2,3, reset (sample dropped), then 4,5,6 -> 26
      tv.push_back('{1'b0, 1'b1, 32'd2, 1'b0, 32'd1,  1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd3, 1'b0, 32'd1,  1'b0});
      tv.push_back('{1'b1, 1'b1, 32'd8, 1'b0, 32'd0,  1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd4, 1'b0, 32'd0,  1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd5, 1'b0, 32'd0,  1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd6, 1'b1, 32'd26, 1'b0});
      tv.push_back('{1'b0, 1'b1, 32'd1, 1'b1, 32'd31, 1'b0});

      for (int i = 0; i < tv.size(); i++) begin
         rst     = tv[i].rst;
         validi  = tv[i].vld;
         data_in = tv[i].din;
         @(posedge clk);
         #1;
         chk("vec_valido", i, 64'(valido), 64'(tv[i].exp_v));
         chk("vec_data_out", i, 64'(data_out), 64'(tv[i].exp_d));
`ifdef EX1_1_MAC3_OVF_EN
         chk("vec_ovf", i, 64'(ovf), 64'(tv[i].exp_o));
`endif
      end

      // Randomized run against the sample-history model; starts from a reset
      for (int i = 0; i < 3000; i++) begin
         rst     = (i == 0) || ($urandom_range(0, 40) == 0);
         validi  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0:       data_in = DW'($urandom_range(0, 15));
            1:       data_in = DW'($urandom_range(0, 32'h3_FFFF));
            default: data_in = $urandom;
         endcase
         @(posedge clk);
         model_edge(rst, validi, data_in);
         #1;
         chk("rnd_valido", i, 64'(valido), 64'(m_valid & ~rst));
         chk("rnd_data_out", i, 64'(data_out), rst ? 64'd0 : 64'(m_data));
`ifdef EX1_1_MAC3_OVF_EN
         chk("rnd_ovf", i, 64'(ovf), 64'(m_ovf & ~rst));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex1_1_mac3.md
EX1_1_MAC3 -- requirements
Module: ex1_1_mac3

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data width of data_in and data_out.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port validi  input  1  marks data_in as valid in the current cycle.
REQ-005 The block SHALL have port data_in  input  DW  input sample, meaningful only when validi=1.
REQ-006 The block SHALL have port valido  output  1  marks data_out as a valid result.
REQ-007 The block SHALL have port data_out  output  DW  result a*b+c.

Function
REQ-008 The block SHALL keep a sample window: c = current data_in, b = data_in one cycle back, a = data_in two cycles back, all three sampled with validi=1.
REQ-009 The block SHALL track the number of consecutive validi=1 cycles in an FSM with states IDLE (0), ONE (1), TWO (2) and RUN (>=3).
REQ-010 The FSM SHALL take these transitions on validi=1: IDLE->ONE, ONE->TWO, TWO->RUN, RUN->RUN.
REQ-011 Any state SHALL go to IDLE on validi=0, and the window SHALL be invalidated so that a new run needs three fresh samples.
REQ-012 When validi=1 in state TWO or RUN at edge n, valido SHALL be 1 and data_out SHALL be a*b+c at edge n+1 (latency 1 cycle after the third consecutive sample).
REQ-013 In state RUN, each further validi=1 cycle SHALL slide the window by one and produce one result per cycle.
REQ-014 valido SHALL be 0 in every other cycle, i.e. after runs of 0, 1 or 2 consecutive validi.
REQ-015 Arithmetic SHALL be unsigned: the 2*DW product plus the DW addend, truncated to the low DW bits (wrap-around, no saturation).
REQ-016 data_out SHALL hold its last value while valido=0, except under reset.
REQ-017 validi=0 followed by validi=1 on the next cycle SHALL restart counting at ONE; samples from before the gap SHALL never be used.

Reset
REQ-018 rst sampled high SHALL return the FSM to IDLE, clear the window registers, and set valido=0 and data_out=0 from the next edge.
REQ-019 While rst=1, data_out and valido SHALL also be forced to 0 combinationally, so that data_out==0 holds in every cycle rst is high.
REQ-020 Reset during a run SHALL discard the partial window, and the first result after rst falls SHALL need three new consecutive samples.
REQ-021 When rst and validi are both 1, rst SHALL take priority and the sample SHALL be dropped.

Configuration
REQ-022 Macro EX1_1_MAC3_OVF_EN defined SHALL add output port ovf (1 bit), equal to 1 with valido when the untruncated a*b+c exceeds 2^DW-1, and 0 otherwise and under reset.
REQ-023 Without EX1_1_MAC3_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Package ex1_1_pkg SHALL hold the default DW constant and the FSM state enum (IDLE, ONE, TWO, RUN).
REQ-025 Sub-module ex1_1_window SHALL implement the 3-entry sample shift window with a valid-flush input, and ex1_1_mac3 SHALL hold the FSM, the multiply-add and the output registers.

Verification
REQ-026 rst=1 for 2 cycles with data_in=0xFFFF_FFFF and validi=1 -> data_out=0 and valido=0 in every rst cycle and in the first cycle after.
REQ-027 validi=1 with data_in 2,3,4 on consecutive cycles -> the next cycle has valido=1 and data_out=10.
REQ-028 validi=1 with data_in 2,3,4,5 then validi=0 -> results 10 then 17 on consecutive cycles, then valido=0 with data_out held at 17.
REQ-029 validi patterns 1,0,1,1,0,1,1,0 -> valido=0 throughout.
REQ-030 data_in 0x10000,0x10000,1 -> data_out=1 (wrap), and ovf=1 with EX1_1_MAC3_OVF_EN.
REQ-031 Samples 2,3 then rst=1 for 1 cycle, then samples 4,5,6 -> first result 26, one cycle after the 6.
